arb3_sched: RTL and testbench

ARB3_SCHED -- requirements
Module: arb3_sched

---
 rtl/arb3_sched.sv | 166 ++++++++++++++++
 tb/tb_arb3_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb3_sched.sv
// arb3_sched: three-requester scheduler sharing one DW-bit accumulator.
// Each granted transaction adds the winner's operand into the accumulator
// over OP_CYCLES busy cycles plus one DONE cycle that delivers the result.
// Build option: define ARB3_SCHED_FIXED_PRIO_EN for fixed priority a > b > c;
// the default build arbitrates round-robin a -> b -> c -> a.
module arb3_sched #(
    parameter int unsigned OP_CYCLES = 3,
    parameter int unsigned DW        = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_a,
    input  logic          i_b,
    input  logic          i_c,
    input  logic [DW-1:0] i_data_a,
    input  logic [DW-1:0] i_data_b,
    input  logic [DW-1:0] i_data_c,
    output logic          o_gnt_a,
    output logic          o_gnt_b,
    output logic          o_gnt_c,
    output logic          o_done_a,
    output logic          o_done_b,
    output logic          o_done_c,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic [DW-1:0] o_c,
    output logic          o_busy
);

    localparam int unsigned CW = 4;
    localparam int unsigned NR = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] opnd_q;
    logic [DW-1:0] res_a_q;
    logic [DW-1:0] res_b_q;
    logic [DW-1:0] res_c_q;
    logic [NR-1:0] gnt_q;
    logic [NR-1:0] done_q;
    logic          busy_q;

    logic [NR-1:0] req_c;
    logic [NR-1:0] win_c;
    logic [DW-1:0] win_data_c;
    logic [DW-1:0] sum_c;

    assign req_c = {i_c, i_b, i_a};

`ifdef ARB3_SCHED_FIXED_PRIO_EN
    // Fixed priority winner: a beats b beats c.
    always_comb begin
        win_c = '0;
        if (req_c[0])      win_c = 3'b001;
        else if (req_c[1]) win_c = 3'b010;
        else if (req_c[2]) win_c = 3'b100;
    end
`else
    logic [NR-1:0] last_q;  // one-hot, last requester granted

    // Round-robin winner: search starts at the requester after last_q.
    always_comb begin
        win_c = '0;
        if (last_q[0]) begin
            if (req_c[1])      win_c = 3'b010;
            else if (req_c[2]) win_c = 3'b100;
            else if (req_c[0]) win_c = 3'b001;
        end else if (last_q[1]) begin
            if (req_c[2])      win_c = 3'b100;
            else if (req_c[0]) win_c = 3'b001;
            else if (req_c[1]) win_c = 3'b010;
        end else begin
            if (req_c[0])      win_c = 3'b001;
            else if (req_c[1]) win_c = 3'b010;
            else if (req_c[2]) win_c = 3'b100;
        end
    end

    // Pointer moves only when a transaction is launched from IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 3'b100;
        end else if (state_q == ST_IDLE && (|req_c)) begin
            last_q <= win_c;
        end
    end
`endif

    // Operand of the winning requester; AND-OR mux on the one-hot winner.
    assign win_data_c = ({DW{win_c[0]}} & i_data_a)
                      | ({DW{win_c[1]}} & i_data_b)
                      | ({DW{win_c[2]}} & i_data_c);

    // Accumulator update, wraps modulo 2^DW.
    assign sum_c = acc_q + opnd_q;

    // Scheduler FSM with registered grant, done, busy and result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_c) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CW'(OP_CYCLES - 1);
                        opnd_q  <= win_data_c;
                        gnt_q   <= win_c;
                        busy_q  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        acc_q   <= sum_c;
                        done_q  <= gnt_q;
                        if (gnt_q[0]) res_a_q <= sum_c;
                        if (gnt_q[1]) res_b_q <= sum_c;
                        if (gnt_q[2]) res_c_q <= sum_c;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_a  = gnt_q[0];
    assign o_gnt_b  = gnt_q[1];
    assign o_gnt_c  = gnt_q[2];
    assign o_done_a = done_q[0];
    assign o_done_b = done_q[1];
    assign o_done_c = done_q[2];
    assign o_a      = res_a_q;
    assign o_b      = res_b_q;
    assign o_c      = res_c_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_arb3_sched.sv
// Bench for arb3_sched (OP_CYCLES=3, DW=8): vector table, directed corner
// sequences, then random requests against a transaction-level model.
// Honors ARB3_SCHED_FIXED_PRIO_EN the same way the design does.
module tb_arb3_sched;

    localparam int OP = 3;

    logic       clk;
    logic       rst_n;
    logic       a, b, c;
    logic [7:0] da, db, dc;
    logic       gnt_a, gnt_b, gnt_c;
    logic       done_a, done_b, done_c;
    logic [7:0] oa, ob, oc;
    logic       busy;

    arb3_sched #(.OP_CYCLES(OP), .DW(8)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_a      (a),
        .i_b      (b),
        .i_c      (c),
        .i_data_a (da),
        .i_data_b (db),
        .i_data_c (dc),
        .o_gnt_a  (gnt_a),
        .o_gnt_b  (gnt_b),
        .o_gnt_c  (gnt_c),
        .o_done_a (done_a),
        .o_done_b (done_b),
        .o_done_c (done_c),
        .o_a      (oa),
        .o_b      (ob),
        .o_c      (oc),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic [7:0] da, db, dc;
        logic [2:0] gnt, done;
        logic       busy;
        logic [7:0] oa, ob, oc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Transaction-level model state.
    logic [7:0] m_acc, m_op;
    logic [7:0] m_res [3];
    int         m_ptr, m_cur, m_gs, m_idle_at;
    logic [2:0] e_gnt, e_done;
    logic       e_busy;

    function automatic void add(input logic r, input logic [2:0] q,
                                input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xc,
                                input logic [2:0] g, input logic [2:0] d, input logic bz,
                                input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] rc);
        vec_t v;
        v.rst_n = r; v.req = q; v.da = xa; v.db = xb; v.dc = xc;
        v.gnt = g; v.done = d; v.busy = bz; v.oa = ra; v.ob = rb; v.oc = rc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = '0; m_op = '0; m_ptr = 2; m_cur = -1; m_gs = 0; m_idle_at = 0;
        for (int i = 0; i < 3; i++) m_res[i] = '0;
        e_gnt = '0; e_done = '0; e_busy = 1'b0;
    endfunction

    // Advance the model across one rising edge using the inputs sampled there.
    function automatic void model_edge();
        logic [2:0] r;
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_cur >= 0 && cyc == m_gs + OP) begin
            m_acc = m_acc + m_op;
            m_res[m_cur] = m_acc;
        end
        r = {c, b, a};
        w = -1;
        if (cyc - 1 >= m_idle_at) begin
`ifdef ARB3_SCHED_FIXED_PRIO_EN
            for (int k = 0; k < 3; k++) if (w < 0 && r[k]) w = k;
`else
            for (int k = 1; k <= 3; k++) if (w < 0 && r[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
`endif
        end
        if (w >= 0) begin
            m_cur = w; m_ptr = w; m_gs = cyc; m_idle_at = cyc + OP + 1;
            m_op = (w == 0) ? da : (w == 1) ? db : dc;
        end
        e_gnt = '0; e_done = '0; e_busy = 1'b0;
        if (m_cur >= 0 && cyc >= m_gs && cyc <= m_gs + OP) begin
            e_gnt[m_cur] = 1'b1;
            e_busy = 1'b1;
        end
        if (m_cur >= 0 && cyc == m_gs + OP) e_done[m_cur] = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("mdl_gnt",  {29'd0, gnt_c, gnt_b, gnt_a},    {29'd0, e_gnt});
        chk("mdl_done", {29'd0, done_c, done_b, done_a}, {29'd0, e_done});
        chk("mdl_busy", {31'd0, busy},                   {31'd0, e_busy});
        chk("mdl_oa",   {24'd0, oa}, {24'd0, m_res[0]});
        chk("mdl_ob",   {24'd0, ob}, {24'd0, m_res[1]});
        chk("mdl_oc",   {24'd0, oc}, {24'd0, m_res[2]});
    endtask

    task automatic set_req(input int x, input logic v, input logic [7:0] d);
        case (x)
            0:       begin a = v; da = d; end
            1:       begin b = v; db = d; end
            default: begin c = v; dc = d; end
        endcase
    endtask

    task automatic txn(input int x, input logic [7:0] d);
        set_req(x, 1'b1, d);
        repeat (OP + 1) tick();
        set_req(x, 1'b0, d);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ea, eb, ec, rv;
        logic [2:0] rq;
        logic       rr [3];
        int ph, pos, who;

        rst_n = 1'b0; a = 0; b = 0; c = 0; da = 0; db = 0; dc = 0;
        model_reset();

        // Reset rows, then a single a-request of 5.
        add(0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add(1, 3'b001, 8'h05, 0, 0, 3'b001, (k == 3) ? 3'b001 : 3'b000, 1,
                (k == 3) ? 8'h05 : 8'h00, 0, 0);
        add(1, 3'b000, 8'h05, 0, 0, 3'b000, 3'b000, 0, 8'h05, 0, 0);
        // Fresh accumulator, all requesters held high with data 1, 2, 3.
        add(0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        ea = 0; eb = 0; ec = 0;
        for (int k = 0; k < 19; k++) begin
            ph = k / 5; pos = k % 5;
`ifdef ARB3_SCHED_FIXED_PRIO_EN
            who = 0; rv = 8'(ph + 1); rq = 3'b101;
`else
            who = ph % 3; rv = (ph == 0) ? 8'd1 : (ph == 1) ? 8'd3 : (ph == 2) ? 8'd6 : 8'd7;
            rq = 3'b111;
`endif
            if (pos == 3) begin
                case (who)
                    0:       ea = rv;
                    1:       eb = rv;
                    default: ec = rv;
                endcase
            end
            add(1, rq, 8'd1, 8'd2, 8'd3,
                (pos < 4) ? 3'(1 << who) : 3'b000,
                (pos == 3) ? 3'(1 << who) : 3'b000,
                pos < 4, ea, eb, ec);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            {c, b, a} = tbl[i].req;
            da = tbl[i].da; db = tbl[i].db; dc = tbl[i].dc;
            tick();
            chk("tbl_gnt",  {29'd0, gnt_c, gnt_b, gnt_a},    {29'd0, tbl[i].gnt});
            chk("tbl_done", {29'd0, done_c, done_b, done_a}, {29'd0, tbl[i].done});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
            chk("tbl_res",  {8'd0, oc, ob, oa}, {8'd0, tbl[i].oc, tbl[i].ob, tbl[i].oa});
        end
        a = 0; b = 0; c = 0;

        // Wrap: 0xF0 + 0x20 -> 0x10 on b only.
        do_reset();
        txn(0, 8'hF0);
        chk("wrap_oa0", {24'd0, oa}, 32'h0000_00F0);
        txn(1, 8'h20);
        chk("wrap_ob", {24'd0, ob}, 32'h0000_0010);
        chk("wrap_oa", {24'd0, oa}, 32'h0000_00F0);
        chk("wrap_oc", {24'd0, oc}, 32'h0000_0000);

        // Request dropped and operand changed mid-transaction.
        set_req(0, 1'b1, 8'h09);
        tick();
        set_req(0, 1'b0, 8'hFF);
        tick(); tick(); tick();
        chk("drop_done", {31'd0, done_a}, 32'd1);
        chk("drop_oa", {24'd0, oa}, 32'h0000_0019);
        tick();
        chk("drop_hold", {24'd0, oa}, 32'h0000_0019);

        // Asynchronous reset in the second BUSY cycle.
        set_req(0, 1'b1, 8'h33);
        tick(); tick();
        set_req(0, 1'b0, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",  {29'd0, gnt_c, gnt_b, gnt_a},    32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {29'd0, done_c, done_b, done_a}, 32'd0);
        chk("arst_res",  {8'd0, oc, ob, oa}, 32'd0);
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        txn(0, 8'h01);
        chk("arst_oa", {24'd0, oa}, 32'h0000_0001);

        // Random requests; a requester holds until its done, then may re-request.
        for (int i = 0; i < 3; i++) rr[i] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!rr[i])                  rr[i] = ($urandom_range(0, 3) == 0);
                else if (e_done[i])          rr[i] = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 49) == 0) rr[i] = 1'b0;
            end
            a = rr[0]; b = rr[1]; c = rr[2];
            da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
